// File: rtl/prog_loader_if.sv
// prog_loader_if: groups the byte-stream handshake and the CPU memory write
// port of the program loader.
//   rx_data/rx_valid/rx_ready : incoming program bytes (valid/ready handshake)
//   mem_addr/mem_wdata/mem_we : word write port into CPU memory
//   cpu_hold/done/err         : CPU freeze and load status
// Modports: master = byte source / memory side, slave = the loader itself.
interface prog_loader_if #(
   parameter int ADDR_W = 12
) ();
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic              cpu_hold;
   logic              done;
   logic              err;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, err
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, mem_addr, mem_wdata, mem_we, cpu_hold, done, err
   );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: receives a program over a byte stream and writes it into CPU
// memory while holding the CPU frozen.
// Stream format: 16-bit big-endian word count, then count 32-bit words, each
// sent most-significant byte first.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset
//   bus   : prog_loader_if.slave (byte handshake, memory write port, status)
module prog_loader #(
   parameter int ADDR_W    = 12,
   parameter int BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          reset,
   prog_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      HDR_HI = 2'd0,
      HDR_LO = 2'd1,
      DATA   = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Largest word count that still fits between BASE_ADDR and the top of memory.
   localparam logic [32:0] LIMIT = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

   state_t            state_r, state_s;
   logic [15:0]       count_r, count_s;
   logic [15:0]       widx_r, widx_s;
   logic [1:0]        bidx_r, bidx_s;
   logic [23:0]       shift_r, shift_s;
   logic              last_r, last_s;
   logic              we_r, we_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [31:0]       wdata_r, wdata_s;
   logic              done_r, done_s;
   logic              err_r, err_s;
   logic              hold_r, hold_s;
   logic              ready_s;
   logic              accept_s;
   logic [15:0]       hdr_s;

   // Ready is gated by reset so nothing is taken while reset is asserted.
   assign ready_s  = (state_r != DONE) && !reset;
   assign accept_s = bus.rx_valid && ready_s;
   assign hdr_s    = {count_r[15:8], bus.rx_data};

   assign bus.rx_ready  = ready_s;
   assign bus.mem_we    = we_r;
   assign bus.mem_addr  = addr_r;
   assign bus.mem_wdata = wdata_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.cpu_hold  = hold_r;

   // Next-state and next-output logic.
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      widx_s  = widx_r;
      bidx_s  = bidx_r;
      shift_s = shift_r;
      last_s  = last_r;
      we_s    = 1'b0;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      done_s  = done_r;
      err_s   = err_r;
      hold_s  = hold_r;
      case (state_r)
         HDR_HI: begin
            if (accept_s) begin
               count_s[15:8] = bus.rx_data;
               state_s       = HDR_LO;
            end else begin
               state_s = HDR_HI;
            end
         end
         HDR_LO: begin
            if (accept_s) begin
               count_s = hdr_s;
               if (hdr_s == 16'd0) begin
                  state_s = DONE;
                  done_s  = 1'b1;
                  hold_s  = 1'b0;
               end else if (33'(hdr_s) <= LIMIT) begin
                  state_s = DATA;
               end else begin
                  state_s = DONE;
                  err_s   = 1'b1;
               end
            end else begin
               state_s = HDR_LO;
            end
         end
         DATA: begin
            if (last_r) begin
               // Final strobe cycle: leave for DONE; any byte taken now is dropped.
               state_s = DONE;
               done_s  = 1'b1;
               hold_s  = 1'b0;
               last_s  = 1'b0;
            end else if (accept_s) begin
               if (bidx_r == 2'd3) begin
                  we_s    = 1'b1;
                  addr_s  = ADDR_W'(32'(BASE_ADDR) + 32'(widx_r));
                  wdata_s = {shift_r, bus.rx_data};
                  widx_s  = widx_r + 16'd1;
                  bidx_s  = 2'd0;
                  last_s  = (widx_r == count_r - 16'd1);
               end else begin
                  shift_s = {shift_r[15:0], bus.rx_data};
                  bidx_s  = bidx_r + 2'd1;
               end
            end else begin
               state_s = DATA;
            end
         end
         DONE: begin
            state_s = DONE;
         end
         default: begin
            state_s = HDR_HI;
         end
      endcase
   end

   // State and output registers; reset wins over any simultaneous byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= HDR_HI;
         count_r <= 16'd0;
         widx_r  <= 16'd0;
         bidx_r  <= 2'd0;
         shift_r <= 24'd0;
         last_r  <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         hold_r  <= 1'b1;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
         widx_r  <= widx_s;
         bidx_r  <= bidx_s;
         shift_r <= shift_s;
         last_r  <= last_s;
         we_r    <= we_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         done_r  <= done_s;
         err_r   <= err_s;
         hold_r  <= hold_s;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed stimulus for prog_loader, checked
// every cycle against a byte-count based model of the load protocol, plus
// literal expectations for the documented example streams.
module tb_prog_loader;

   localparam int ADDR_W    = 12;
   localparam int BASE_ADDR = 0;
   localparam int LIMIT     = (1 << ADDR_W) - BASE_ADDR;

   logic clk = 1'b0;
   logic reset;

   prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // model of the expected outputs
   bit                m_valid = 1'b0;
   bit                m_fin   = 1'b0;
   bit                m_pend  = 1'b0;
   int                m_nacc  = 0;
   int                m_count = 0;
   logic [7:0]        m_hi    = 8'd0;
   logic [31:0]       m_word  = 32'd0;
   logic              m_we    = 1'b0;
   logic [ADDR_W-1:0] m_addr  = '0;
   logic [31:0]       m_wdata = 32'd0;
   logic              m_done  = 1'b0;
   logic              m_err   = 1'b0;
   logic              m_hold  = 1'b1;
   bit                last_acc = 1'b0;

   logic [7:0]  src[$];
   int          log_addr[$];
   logic [31:0] log_data[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive, compare, advance the model on the edge.
   task automatic step(input logic rst, input logic v, input logic [7:0] d);
      bit exp_ready;
      reset        = rst;
      bus.rx_valid = v;
      bus.rx_data  = d;
      exp_ready    = !rst && !m_fin;
      #1;
      check("ready", bus.rx_ready, exp_ready);
      if (m_valid) begin
         check("we",    bus.mem_we,    m_we);
         check("addr",  bus.mem_addr,  m_addr);
         check("wdata", bus.mem_wdata, m_wdata);
         check("done",  bus.done,      m_done);
         check("err",   bus.err,       m_err);
         check("hold",  bus.cpu_hold,  m_hold);
      end
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b1; m_fin = 1'b0; m_pend = 1'b0; m_nacc = 0;
         m_we = 1'b0; m_addr = '0; m_wdata = 32'd0;
         m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1; last_acc = 1'b0;
      end else begin
         last_acc = v && exp_ready;
         m_we = 1'b0;
         if (m_pend) begin
            m_pend = 1'b0; m_fin = 1'b1; m_done = 1'b1; m_hold = 1'b0;
         end else if (last_acc) begin
            m_nacc++;
            if (m_nacc == 1) begin
               m_hi = d;
            end else if (m_nacc == 2) begin
               m_count = int'({m_hi, d});
               if (m_count == 0) begin
                  m_fin = 1'b1; m_done = 1'b1; m_hold = 1'b0;
               end else if (m_count > LIMIT) begin
                  m_fin = 1'b1; m_err = 1'b1;
               end
            end else begin
               m_word = {m_word[23:0], d};
               if ((m_nacc - 2) % 4 == 0) begin
                  m_we    = 1'b1;
                  m_addr  = ADDR_W'(BASE_ADDR + (m_nacc - 2) / 4 - 1);
                  m_wdata = m_word;
                  if ((m_nacc - 2) / 4 == m_count) m_pend = 1'b1;
               end
            end
         end
      end
      #1;
      if (bus.mem_we === 1'b1) begin
         log_addr.push_back(int'(bus.mem_addr));
         log_data.push_back(bus.mem_wdata);
      end
   endtask

   task automatic do_reset();
      src.delete();
      log_addr.delete();
      log_data.delete();
      step(1'b1, 1'b0, 8'($urandom));
      step(1'b1, 1'b1, 8'($urandom));
   endtask

   // Feed src: each cycle offer the head byte with probability prob, then
   // idle for gap cycles after every accepted byte.
   task automatic run(input int ncyc, input int prob, input int gap);
      int idle;
      logic v;
      logic [7:0] d;
      idle = 0;
      for (int i = 0; i < ncyc; i++) begin
         v = 1'b0;
         d = 8'($urandom);
         if (idle > 0) begin
            idle--;
         end else if (src.size() > 0 && $urandom_range(0, 99) < prob) begin
            v = 1'b1;
            d = src[0];
         end
         step(1'b0, v, d);
         if (last_acc) begin
            void'(src.pop_front());
            idle = gap;
         end
      end
   endtask

   function automatic logic [31:0] log_d(input int i);
      return (log_data.size() > i) ? log_data[i] : 32'hxxxxxxxx;
   endfunction

   function automatic logic [31:0] log_a(input int i);
      return (log_addr.size() > i) ? 32'(log_addr[i]) : 32'hxxxxxxxx;
   endfunction

   initial begin
      logic [7:0]  bytes[$];
      logic [31:0] w;
      int cnt, extra, prob, gap;
      bit full;

      // reset state
      do_reset();
      check("rst_ready", bus.rx_ready, 32'd0);
      check("rst_we",    bus.mem_we,   32'd0);
      check("rst_hold",  bus.cpu_hold, 32'd1);
      check("rst_done",  bus.done,     32'd0);
      check("rst_addr",  bus.mem_addr, 32'd0);

      // two-word program, valid held high
      do_reset();
      src = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h23, 8'hBD, 8'hFF, 8'hFC};
      run(16, 100, 0);
      check("ex_nwr",  log_data.size(), 32'd2);
      check("ex_a0",   log_a(0), 32'd0);
      check("ex_d0",   log_d(0), 32'h20080005);
      check("ex_a1",   log_a(1), 32'd1);
      check("ex_d1",   log_d(1), 32'h23BDFFFC);
      check("ex_done", bus.done, 32'd1);
      check("ex_hold", bus.cpu_hold, 32'd0);

      // empty program
      do_reset();
      src = '{8'h00, 8'h00};
      run(6, 100, 0);
      check("z_nwr",   log_data.size(), 32'd0);
      check("z_done",  bus.done, 32'd1);
      check("z_ready", bus.rx_ready, 32'd0);
      check("z_hold",  bus.cpu_hold, 32'd0);

      // header one past the end of memory
      do_reset();
      src = '{8'h10, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run(10, 100, 0);
      check("e_err",  bus.err, 32'd1);
      check("e_done", bus.done, 32'd0);
      check("e_hold", bus.cpu_hold, 32'd1);
      check("e_nwr",  log_data.size(), 32'd0);
      check("e_left", src.size(), 32'd4);

      // header exactly filling memory is accepted
      do_reset();
      src = '{8'h10, 8'h00};
      run(4, 100, 0);
      check("b_err",   bus.err, 32'd0);
      check("b_ready", bus.rx_ready, 32'd1);

      // gaps of three idle cycles between bytes
      do_reset();
      src = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      run(40, 100, 3);
      check("g_nwr",  log_data.size(), 32'd1);
      check("g_d0",   log_d(0), 32'h12345678);
      check("g_done", bus.done, 32'd1);

      // reset mid-load, then a fresh stream
      do_reset();
      src = '{8'h00, 8'h02, 8'h11, 8'h22};
      run(6, 100, 0);
      check("m_nwr", log_data.size(), 32'd0);
      do_reset();
      src = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run(10, 100, 0);
      check("m_nwr2", log_data.size(), 32'd1);
      check("m_a0",   log_a(0), 32'd0);
      check("m_d0",   log_d(0), 32'hDEADBEEF);

      // bytes after done are not taken and change nothing
      src = '{8'h01, 8'h02, 8'h03};
      run(6, 100, 0);
      check("pd_nwr",  log_data.size(), 32'd1);
      check("pd_left", src.size(), 32'd3);
      check("pd_done", bus.done, 32'd1);

      // randomized streams
      for (int r = 0; r < 40; r++) begin
         do_reset();
         case ($urandom_range(0, 9))
            0:       cnt = 0;
            1:       cnt = LIMIT + 1 + int'($urandom_range(0, 3));
            default: cnt = int'($urandom_range(1, 5));
         endcase
         bytes.delete();
         bytes.push_back(8'(cnt >> 8));
         bytes.push_back(8'(cnt));
         for (int k = 0; k < 4 * ((cnt > LIMIT) ? 2 : cnt); k++) bytes.push_back(8'($urandom));
         extra = int'($urandom_range(0, 3));
         for (int k = 0; k < extra; k++) bytes.push_back(8'($urandom));
         src  = bytes;
         prob = int'($urandom_range(50, 100));
         gap  = int'($urandom_range(0, 2));
         full = (r % 5 != 4);
         run(full ? bytes.size() * 10 + 10 : bytes.size() * 2, prob, gap);
         if (full && cnt <= LIMIT) begin
            check("r_nwr",  log_data.size(), 32'(cnt));
            check("r_done", bus.done, 32'd1);
            for (int k = 0; k < cnt; k++) begin
               w = {bytes[2 + 4 * k], bytes[3 + 4 * k], bytes[4 + 4 * k], bytes[5 + 4 * k]};
               check("r_addr", log_a(k), 32'(BASE_ADDR + k));
               check("r_data", log_d(k), w);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the CPU memory (4096 words).
REQ-002 SHALL have parameter BASE_ADDR, default 0, word address of the first loaded word.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  incoming program byte.
REQ-006 SHALL have port rx_valid  input  1  rx_data holds a valid byte.
REQ-007 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port mem_addr  output  ADDR_W  word address into CPU memory.
REQ-009 SHALL have port mem_wdata  output  32  instruction/data word to write.
REQ-010 SHALL have port mem_we  output  1  single-cycle memory write strobe.
REQ-011 SHALL have port cpu_hold  output  1  holds the CPU (PC and register writes) frozen while high.
REQ-012 SHALL have port done  output  1  load completed successfully.
REQ-013 SHALL have port err  output  1  load aborted on invalid header.

Function
REQ-014 SHALL accept a byte only on a rising edge where rx_valid and rx_ready are both 1; rx_valid without rx_ready is ignored.
REQ-015 SHALL implement states HDR_HI, HDR_LO, DATA, DONE; reset enters HDR_HI.
REQ-016 SHALL, in HDR_HI, capture the accepted byte as count[15:8] and move to HDR_LO.
REQ-017 SHALL, in HDR_LO, capture count[7:0] and move to DATA if 0 < count <= 2^ADDR_W - BASE_ADDR; to DONE with done=1 if count=0; to DONE with err=1 otherwise.
REQ-018 SHALL, in DATA, assemble bytes big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-019 SHALL, on the cycle after the 4th byte of a word is accepted, assert mem_we for exactly one cycle with mem_addr = BASE_ADDR + word index (0-based) and mem_wdata = assembled word.
REQ-020 SHALL keep rx_ready=1 during the write-strobe cycle so back-to-back words stream at one byte per cycle.
REQ-021 SHALL, after the write of word count-1, enter DONE on the same edge that ends the strobe; done=1 and cpu_hold=0 from the following cycle.
REQ-022 SHALL drive rx_ready=1 in HDR_HI, HDR_LO, DATA and 0 in DONE.
REQ-023 SHALL hold mem_addr and mem_wdata at their last written values when mem_we=0.
REQ-024 SHALL drive cpu_hold=1 in every state except DONE with err=0.
REQ-025 SHALL remain in DONE, ignoring rx_valid, until reset; done and err are mutually exclusive.
REQ-026 SHALL NOT write memory for a partial word.

Reset
REQ-027 SHALL, on reset high at a rising edge, set state HDR_HI, byte index 0, word index 0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, cpu_hold=1, rx_ready=0 during the reset cycle.
REQ-028 SHALL, on reset mid-load, discard any partial word, suppress any pending write strobe and restart expecting a header.
REQ-029 SHALL give reset priority over a simultaneous byte acceptance.

Verification
REQ-030 Bytes 00 02 20 08 00 05 23 BD FF FC, rx_valid held high -> mem_we pulses write [0]=0x20080005, [1]=0x23BDFFFC; done=1, cpu_hold=0 one cycle after second pulse.
REQ-031 Header 00 00 -> no mem_we, done=1, rx_ready=0, cpu_hold=0.
REQ-032 Header 10 01 with ADDR_W=12 -> err=1, done=0, cpu_hold stays 1, no mem_we, later bytes ignored.
REQ-033 Header 00 01, data bytes with rx_valid low for 3 cycles between each -> single write [0]=assembled word, no extra strobes.
REQ-034 Header 00 02, 2 data bytes, then reset -> no mem_we; new stream 00 01 DE AD BE EF writes [0]=0xDEADBEEF.
REQ-035 Bytes presented after done -> rx_ready=0, mem_we never asserts, outputs unchanged.
